// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory controller state encoding and word geometry.
package cpu_pkg;

  localparam int D_WORD     = 32;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = D_WORD / BYTE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/data_mem_ctrl.sv
// Serves 32-bit little-endian word reads/writes from the pipeline against a byte-wide
// synchronous SRAM, one byte per cycle, stalling the pipeline until the access completes.
module data_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_data_wr,
  output logic [31:0]       mem_data_rd,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_error,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata
);

  localparam int IDX_W = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  dmem_state_t               state_r;
  dmem_state_t               state_s;
  logic [IDX_W-1:0]          idx_r;
  logic [IDX_W-1:0]          prev_idx_s;
  logic [ADDR_W-1:0]         addr_r;
  logic [D_WORD-1:0]         data_r;
  logic                      is_wr_r;
  logic                      err_r;
  logic [D_WORD-BYTE_W-1:0]  asm_r;
  logic [D_WORD-1:0]         rd_r;
  logic                      req_s;
  logic                      req_err_s;
  logic [32:0]               end_addr_s;

  // 33-bit end address so requests near 0xFFFF_FFFF are rejected instead of wrapping
  assign end_addr_s = {1'b0, mem_addr} + 33'(WORD_BYTES - 1);
  assign req_s      = mem_read | mem_write;
  assign req_err_s  = (mem_read & mem_write) | (|end_addr_s[32:ADDR_W]);
  assign prev_idx_s = idx_r - IDX_W'(1);

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_s = req_err_s ? DONE : XFER;
        end else begin
          state_s = IDLE;
        end
      end
      XFER: begin
        if (idx_r == LAST_IDX) begin
          state_s = is_wr_r ? DONE : DRAIN;
        end else begin
          state_s = XFER;
        end
      end
      DRAIN:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, request latch, byte index and read assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      addr_r  <= '0;
      data_r  <= '0;
      is_wr_r <= 1'b0;
      err_r   <= 1'b0;
      asm_r   <= '0;
      rd_r    <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            addr_r  <= mem_addr[ADDR_W-1:0];
            data_r  <= mem_data_wr;
            is_wr_r <= mem_write;
            err_r   <= req_err_s;
            idx_r   <= '0;
          end
        end
        XFER: begin
          idx_r <= idx_r + IDX_W'(1);
          // SRAM answers one cycle late: the byte on sram_rdata belongs to idx_r-1
          if (!is_wr_r && (idx_r != '0)) begin
            for (int b = 0; b < WORD_BYTES - 1; b++) begin
              if (prev_idx_s == IDX_W'(b)) begin
                asm_r[BYTE_W*b +: BYTE_W] <= sram_rdata;
              end
            end
          end
        end
        DRAIN: begin
          rd_r <= {sram_rdata, asm_r};
        end
        DONE: begin
          err_r <= 1'b0;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  // Pipeline-side handshake and SRAM drive, decoded from state
  always_comb begin
    mem_busy   = 1'b0;
    mem_done   = 1'b0;
    mem_error  = 1'b0;
    sram_addr  = '0;
    sram_we    = 1'b0;
    sram_wdata = 8'h00;
    case (state_r)
      IDLE:  mem_busy = req_s;
      XFER: begin
        mem_busy  = 1'b1;
        sram_addr = addr_r + ADDR_W'(idx_r);
        if (is_wr_r) begin
          sram_we    = 1'b1;
          sram_wdata = data_r[BYTE_W*idx_r +: BYTE_W];
        end else begin
          sram_we    = 1'b0;
        end
      end
      DRAIN: mem_busy = 1'b1;
      DONE: begin
        mem_done  = 1'b1;
        mem_error = err_r;
      end
      default: mem_busy = 1'b0;
    endcase
  end

  assign mem_data_rd = rd_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized scoreboard bench for data_mem_ctrl with a behavioural byte SRAM and word-level model.
module tb_data_mem_ctrl;

  localparam int ADDR_W = 16;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [31:0]       mem_addr = 32'h0;
  logic [31:0]       mem_data_wr = 32'h0;
  logic [31:0]       mem_data_rd;
  logic              mem_busy;
  logic              mem_done;
  logic              mem_error;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we;
  logic [7:0]        sram_wdata;
  logic [7:0]        sram_rdata;

  data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_error(mem_error),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    logic [7:0] v;
    v = 8'(i * 37 + 11) ^ 8'(i >> 8);
    if (i == 2) v = 8'h5A;
    return v;
  endfunction

  // Behavioural byte SRAM, one-cycle read latency; filled on its first clock
  logic [7:0] sram [MEM_SZ];
  bit         sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < MEM_SZ; i++) sram[i] <= init_byte(i);
      sram_init  <= 1'b1;
      sram_rdata <= 8'h00;
    end else begin
      if (sram_we) sram[sram_addr] <= sram_wdata;
      sram_rdata <= sram[sram_addr];
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [MEM_SZ];
  logic [31:0] last_rd = 32'h0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion pops the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && mem_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", mem_data_rd, e.data);
        check("error", {31'd0, mem_error}, {31'd0, e.err});
      end
    end
  end

  // Issue one request, hold it until completion, check latency/busy/sram_we along the way
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input bit wiggle);
    exp_t e;
    logic [32:0] end_a;
    int exp_lat, c0, n;
    bit done;
    end_a = {1'b0, addr} + 33'd3;
    e.err = (rd & wr) || (end_a > 33'(MEM_SZ - 1));
    if (e.err) begin
      e.data  = last_rd;
      exp_lat = 2;
    end else if (wr) begin
      for (int b = 0; b < 4; b++) ref_mem[16'(addr + 32'(b))] = data[8*b +: 8];
      e.data  = last_rd;
      exp_lat = 6;
    end else begin
      for (int b = 0; b < 4; b++) e.data[8*b +: 8] = ref_mem[16'(addr + 32'(b))];
      last_rd = e.data;
      exp_lat = 7;
    end
    exp_q.push_back(e);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_addr = addr; mem_data_wr = data;
    c0 = cyc; n = 0; done = 1'b0;
    while (!done && n < 20) begin
      #1;
      if (mem_done) begin
        done = 1'b1;
        check("latency", 32'(cyc - c0 + 1), 32'(exp_lat));
        check("busy_in_done", {31'd0, mem_busy}, 32'd0);
      end else begin
        check("busy", {31'd0, mem_busy}, 32'd1);
        if (e.err || rd) check("no_sram_we", {31'd0, sram_we}, 32'd0);
        if (wiggle && n > 0) begin
          mem_addr = $urandom; mem_data_wr = $urandom;
        end
        @(negedge clk);
        n++;
      end
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = 32'h0; mem_data_wr = 32'h0;
  endtask

  task automatic check_sram(input string name, input int a, input logic [7:0] exp);
    check(name, {24'd0, sram[a]}, {24'd0, exp});
  endtask

  // Abandon a write @0x0200 by raising rst during its third byte
  task automatic reset_mid_write();
    @(negedge clk);
    mem_write = 1'b1; mem_addr = 32'h0000_0200; mem_data_wr = 32'hCAFE_BABE;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pre_we", {31'd0, sram_we}, 32'd1);
    check("rst_pre_addr", {16'd0, sram_addr}, 32'h0202);
    mem_write = 1'b0; mem_addr = 32'h0; mem_data_wr = 32'h0;
    rst = 1'b1;
    #1;
    check("rst_we_drop", {31'd0, sram_we}, 32'd0);
    check("rst_busy", {31'd0, mem_busy}, 32'd0);
    check("rst_done", {31'd0, mem_done}, 32'd0);
    ref_mem[16'h0200] = 8'hBE;
    ref_mem[16'h0201] = 8'hBA;
    last_rd = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("rst_no_done", {31'd0, mem_done}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int r;
    for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_byte(i);
    repeat (3) @(negedge clk);
    #1;
    check("rst_data_rd", mem_data_rd, 32'h0);
    check("rst_outputs", {mem_busy, mem_done, mem_error, sram_we, 4'h0, sram_wdata, sram_addr},
          32'h0);
    rst = 1'b0;

    do_op(1'b0, 1'b1, 32'h0000_0100, 32'h1122_3344, 1'b0);
    @(negedge clk);
    check_sram("t1_b0", 16'h0100, 8'h44);
    check_sram("t1_b1", 16'h0101, 8'h33);
    check_sram("t1_b2", 16'h0102, 8'h22);
    check_sram("t1_b3", 16'h0103, 8'h11);
    do_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    check("t2_word", last_rd, mem_data_rd);

    do_op(1'b0, 1'b1, 32'h0000_0003, 32'hA1B2_C3D4, 1'b0);
    do_op(1'b1, 1'b0, 32'h0000_0002, 32'h0, 1'b0);
    check("t3_word", mem_data_rd, 32'hB2C3_D45A);
    check_sram("t3_b3", 3, 8'hD4);
    check_sram("t3_b6", 6, 8'hA1);

    do_op(1'b1, 1'b0, 32'h0000_FFFE, 32'h0, 1'b0);
    do_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0);
    do_op(1'b1, 1'b0, 32'h0000_FFFC, 32'h0, 1'b0);
    do_op(1'b1, 1'b1, 32'h0000_0100, 32'h0, 1'b0);
    do_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    check("t5_word", mem_data_rd, 32'h1122_3344);

    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h0000_FFF0 + 32'($urandom_range(0, 15));
      else             a = 32'($urandom_range(0, 1023));
      r = $urandom_range(0, 19);
      do_op(r < 9 || r == 19, r >= 9, a, $urandom, 1'($urandom_range(0, 1)));
    end

    reset_mid_write();
    check_sram("t6_b0", 16'h0200, 8'hBE);
    check_sram("t6_b1", 16'h0201, 8'hBA);
    check_sram("t6_b2", 16'h0202, ref_mem[16'h0202]);
    check_sram("t6_b3", 16'h0203, ref_mem[16'h0203]);
    do_op(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
